// File: rtl/ns_msg_relay_pkg.sv
// Shared widths, FSM encodings and the debouncer macro for the ns_msg_relay stage.
// Field sizes come from the codebase-wide NS_* defines; the defaults apply when no build sets them.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 3
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

// ckd_ takes the level of sig_ once sig_ has differed from it for cks_ consecutive samples.
`ifndef NS_DEBOUNCE
`define NS_DEBOUNCE(clk_, rst_n_, sig_, ckd_, cnt_, cks_) \
    always_ff @(posedge clk_ or negedge rst_n_) begin \
        if (!rst_n_) begin \
            cnt_ <= '0; \
            ckd_ <= 1'b0; \
        end else if (sig_ == ckd_) begin \
            cnt_ <= '0; \
        end else if (cnt_ == DB_CNT_W'(cks_ - 1)) begin \
            cnt_ <= '0; \
            ckd_ <= sig_; \
        end else begin \
            cnt_ <= cnt_ + 1'b1; \
        end \
    end
`endif

package ns_msg_relay_pkg;

    localparam int NS_ASZ       = `NS_ADDRESS_SIZE;
    localparam int NS_DSZ       = `NS_DATA_SIZE;
    localparam int NS_RSZ       = `NS_REDUN_SIZE;
    localparam int NS_REQ_CKS_P = `NS_REQ_CKS;
    localparam int NS_ACK_CKS_P = `NS_ACK_CKS;

    localparam int ERR_W    = 8;
    localparam int DB_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ACK   = 2'd2,
        S_REL   = 2'd3
    } sink_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_WAIT = 2'd1,
        O_REL  = 2'd2
    } src_state_t;

endpackage

// File: rtl/ns_msg_relay_calc_redun.sv
// Redundancy code for a message: XOR fold of {src, dst, dat} in RSZ-bit chunks, LSB aligned.
module calc_redun
    import ns_msg_relay_pkg::*;
#(
    parameter int ASZ = NS_ASZ,
    parameter int DSZ = NS_DSZ,
    parameter int RSZ = NS_RSZ
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    localparam int MW     = 2 * ASZ + DSZ;
    localparam int CHUNKS = (MW + RSZ - 1) / RSZ;

    logic [MW-1:0] msg;

    assign msg = {src, dst, dat};

    always_comb begin
        red = '0;
        for (int j = 0; j < CHUNKS; j++) begin
            red = red ^ RSZ'(msg >> (j * RSZ));
        end
    end

endmodule

// File: rtl/ns_msg_relay.sv
// Message relay: debounced 4-phase input channel, redundancy check, DEPTH-entry ring,
// and a 4-phase output channel that re-issues good messages in arrival order.
module ns_msg_relay
    import ns_msg_relay_pkg::*;
#(
    parameter int ASZ         = NS_ASZ,
    parameter int DSZ         = NS_DSZ,
    parameter int RSZ         = NS_RSZ,
    parameter int DEPTH       = 4,
    parameter int RCV_REQ_CKS = NS_REQ_CKS_P,
    parameter int SND_ACK_CKS = NS_ACK_CKS_P
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ASZ-1:0]   i_src,
    input  logic [ASZ-1:0]   i_dst,
    input  logic [DSZ-1:0]   i_dat,
    input  logic [RSZ-1:0]   i_red,
    input  logic             i_req,
    output logic             i_ack,
    output logic [ASZ-1:0]   o_src,
    output logic [ASZ-1:0]   o_dst,
    output logic [DSZ-1:0]   o_dat,
    output logic [RSZ-1:0]   o_red,
    output logic             o_req,
    input  logic             o_ack,
    output logic [ERR_W-1:0] err_cnt,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MSG_W = 2 * ASZ + DSZ + RSZ;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic                ckd_req, ckd_ack;
    logic [DB_CNT_W-1:0] req_cnt, ack_cnt;

    sink_state_t sink_state, sink_next;
    src_state_t  src_state, src_next;

    logic [ASZ-1:0] lat_src, lat_dst;
    logic [DSZ-1:0] lat_dat;
    logic [RSZ-1:0] lat_red, calc_red;
    logic           latch_en, push, drop, i_ack_next;
    logic           load, pop, o_req_next;

    logic [MSG_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, next_count;
    logic [MSG_W-1:0] head;

    `NS_DEBOUNCE(clk, reset, i_req, ckd_req, req_cnt, RCV_REQ_CKS)
    `NS_DEBOUNCE(clk, reset, o_ack, ckd_ack, ack_cnt, SND_ACK_CKS)

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
        .src(lat_src),
        .dst(lat_dst),
        .dat(lat_dat),
        .red(calc_red)
    );

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sink_next  = sink_state;
        latch_en   = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        i_ack_next = i_ack;
        unique case (sink_state)
            S_IDLE: if (ckd_req && !i_ack && !full) begin
                latch_en  = 1'b1;
                sink_next = S_CHECK;
            end
            S_CHECK: begin
                push       = (lat_red == calc_red);
                drop       = (lat_red != calc_red);
                i_ack_next = 1'b1;
                sink_next  = S_ACK;
            end
            S_ACK: sink_next = S_REL;
            S_REL: if (!ckd_req) begin
                i_ack_next = 1'b0;
                sink_next  = S_IDLE;
            end
            default: sink_next = S_IDLE;
        endcase
    end

    // An empty ring forwards the message being pushed, so pass-through costs no extra cycle.
    assign head = empty ? {lat_src, lat_dst, lat_dat, lat_red} : ring[rd_ptr];

    always_comb begin
        src_next   = src_state;
        load       = 1'b0;
        pop        = 1'b0;
        o_req_next = o_req;
        unique case (src_state)
            O_IDLE: if ((!empty || push) && !ckd_ack) begin
                load       = 1'b1;
                o_req_next = 1'b1;
                src_next   = O_WAIT;
            end
            O_WAIT: if (ckd_ack) begin
                pop        = 1'b1;
                o_req_next = 1'b0;
                src_next   = O_REL;
            end
            O_REL: if (!ckd_ack) src_next = O_IDLE;
            default: src_next = O_IDLE;
        endcase
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sink_state <= S_IDLE;
            src_state  <= O_IDLE;
            i_ack      <= 1'b0;
            o_req      <= 1'b0;
            lat_src    <= '0;
            lat_dst    <= '0;
            lat_dat    <= '0;
            lat_red    <= '0;
            o_src      <= '0;
            o_dst      <= '0;
            o_dat      <= '0;
            o_red      <= '0;
            err_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            sink_state <= sink_next;
            src_state  <= src_next;
            i_ack      <= i_ack_next;
            o_req      <= o_req_next;
            if (latch_en) begin
                lat_src <= i_src;
                lat_dst <= i_dst;
                lat_dat <= i_dat;
                lat_red <= i_red;
            end
            if (load) {o_src, o_dst, o_dat, o_red} <= head;
            if (drop && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= next_count;
            full  <= (next_count == CNT_FULL);
            empty <= (next_count == '0);
        end
    end

    // NOTE: ring storage has no reset; count/empty guard every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) ring[wr_ptr] <= {lat_src, lat_dst, lat_dat, lat_red};
    end

endmodule

// File: doc/ns_msg_relay.md
# ns_msg_relay

Single-clock message relay stage between a channel producer (for example the counter-driven message source used in the fifo test) and a channel consumer.
- Accepts messages on a 4-phase req/ack input channel and verifies each message's redundancy field.
- Buffers good messages in a DEPTH-entry ring and re-issues them on a 4-phase req/ack output channel.
- Drops corrupt messages and counts them, giving the checking sink a clean, back-pressured stream.

## Interface
- ASZ, `NS_ADDRESS_SIZE, address field width (src, dst)
- DSZ, `NS_DATA_SIZE, data field width
- RSZ, `NS_REDUN_SIZE, redundancy field width
- DEPTH, 4, ring entries; power of two, ≥2
- RCV_REQ_CKS, `NS_REQ_CKS, consecutive stable samples required to accept an i_req level
- SND_ACK_CKS, `NS_ACK_CKS, consecutive stable samples required to accept an o_ack level
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- i_src/i_dst  in  ASZ  incoming message addresses
- i_dat  in  DSZ  incoming data
- i_red  in  RSZ  incoming redundancy
- i_req  in  1  incoming request, 4-phase
- i_ack  out  1  incoming acknowledge
- o_src/o_dst  out  ASZ  outgoing message addresses
- o_dat  out  DSZ  outgoing data
- o_red  out  RSZ  outgoing redundancy, forwarded unchanged
- o_req  out  1  outgoing request
- o_ack  in  1  outgoing acknowledge
- err_cnt  out  8  count of dropped messages; saturates at 255
- full  out  1  ring holds DEPTH entries
- empty  out  1  ring holds 0 entries

## Operation
- **Debounce.**
  - i_req feeds a stability counter; ckd_req takes the new level only after RCV_REQ_CKS consecutive equal samples.
  - o_ack is debounced the same way into ckd_ack using SND_ACK_CKS.
- **Sink FSM** (S_IDLE, S_CHECK, S_ACK, S_REL):
  - S_IDLE: if ckd_req && !i_ack && !full, latch i_* fields and go to S_CHECK. When full, stay in S_IDLE; this is back-pressure and no ack is given.
  - S_CHECK: compare latched red against calc_redun(src,dst,dat). On match, push the message. On mismatch, discard it and increment err_cnt (saturating). Go to S_ACK.
  - S_ACK: drive i_ack=1 and go to S_REL.
  - S_REL: when ckd_req==0, drive i_ack=0 and go to S_IDLE.
- **Source FSM** (O_IDLE, O_WAIT, O_REL):
  - O_IDLE: if !empty && !ckd_ack, copy the ring head into the o_* registers, set o_req=1, go to O_WAIT.
  - O_WAIT: when ckd_ack==1, pop the head, set o_req=0, go to O_REL.
  - O_REL: when ckd_ack==0, go to O_IDLE.
- **o_* hold rule:** o_* fields are stable from the cycle o_req rises until ckd_ack is seen.
- **Ring pointers:** wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- **Simultaneous push and pop:** count is unchanged, both pointers advance, and the entry being popped is never overwritten.
- **Ordering:** messages leave in arrival order, with fields bit-identical to the input.

## Timing
- **Reset values:** i_ack=0, o_req=0, o_src/o_dst/o_dat/o_red=0, err_cnt=0, empty=1, full=0. Both FSMs are in their IDLE states and the debounce counters are 0.
- **Input side:** i_req rise → i_ack rise is RCV_REQ_CKS+2 cycles (debounce, S_CHECK, S_ACK).
- **Pass-through:** push → o_req rise is 1 cycle when the source FSM is idle and ckd_ack==0. Total empty-ring pass-through is RCV_REQ_CKS+2 cycles to o_req.
- **Output side:** o_ack rise → o_req fall is SND_ACK_CKS+1 cycles.
- **full/empty:** registered; they update in the cycle after the push or pop.
- **Reset mid-transfer:** i_ack and o_req drop immediately, ring contents are lost, and err_cnt returns to 0. The upstream sender sees ack low and re-handshakes.
- **Glitches:** an i_req pulse shorter than RCV_REQ_CKS cycles is ignored.

## Structure
- Shared package/header holds:
  - the state encodings for both FSMs;
  - the err_cnt width (8);
  - the message field widths, reusing the existing NS_ADDRESS/DATA/REDUN size defines.
- Sub-module: existing calc_redun, one instance on the latched input fields.
- Debouncers are implemented with the existing debouncer macros.
- Ring storage is inline.

## Test plan
- **Single message:** reset low for 3 cycles then high. Send src=0, dst=1, dat=5 with correct red → i_ack handshake completes, o_* carry identical fields, o_req rises RCV_REQ_CKS+2 cycles after i_req, err_cnt=0.
- **Bad redundancy:** send dat=7 with red flipped → i_ack still completes, no o_req, err_cnt=1, empty stays 1.
- **Back-pressure:** hold o_ack=0 and send 5 messages dat=0..4 → ring holds four, so 4 acks plus 1 in flight on the output. The 5th i_req stays unacked while full=1. Release o_ack → all 5 arrive in order 0..4.
- **Wrap-around:** stream 16 messages dat=0..15 with a random o_ack delay of 0–10 cycles → output sequence is strictly +1 with no loss; pointers wrap 4 times.
- **Saturation:** send 260 bad messages → err_cnt=255 and stays there.
- **Reset mid-transfer:** assert reset with o_req=1 and 2 entries stored → o_req=0, i_ack=0 and empty=1 immediately. The next good message is relayed normally.
